knn_pio_edge_irq: RTL

Parametrised Avalon-MM input PIO for the Nios II SOPC. It is the successor to the single-bit status input ports used for KNN handshake flags such as "classe prevista pronto". It synchronises a WIDTH-bit asynchronous input bus and detects edges per bit into a sticky capture register. It raises a maskable level interrupt so firmware no longer polls the KNN accelerator's done and status flags.

---
 rtl/knn_pio_edge_irq.sv | 106 ++++++++++
 1 files changed

// File: rtl/knn_pio_edge_irq.sv
// Avalon-MM input PIO: synchronises a status bus, captures per-bit edges into a
// sticky write-1-to-clear register and raises a maskable level interrupt.
module knn_pio_edge_irq #(
  parameter int          WIDTH          = 8,
  parameter int          EDGE_TYPE      = 0,
  parameter int          SYNC_STAGES    = 2,
  parameter logic [31:0] IRQ_MASK_RESET = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int            CW       = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_TERM = CW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] wr_data;
  logic [CW-1:0]    arm_cnt;
  logic             armed;
  logic             wr_mask;
  logic             wr_clr;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign wr_data   = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign armed     = (arm_cnt == ARM_TERM);
  assign wr_mask   = chipselect & ~write_n & (address == 2'd2);
  assign wr_clr    = chipselect & ~write_n & (address == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync;
    end
  end

  // Edges are suppressed until the synchroniser and prev flop hold real input
  // samples, so levels present at reset release are not seen as edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + CW'(1);
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      1:       edge_raw = ~sync & prev;
      2:       edge_raw = sync ^ prev;
      default: edge_raw = sync & ~prev;
    endcase
    edge_vec = armed ? edge_raw : '0;
  end

  // A new edge overrides a simultaneous clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
      irqmask     <= IRQ_MASK_RESET[WIDTH-1:0];
      irq         <= 1'b0;
    end else begin
      edgecapture <= (edgecapture & ~(wr_clr ? wr_data : '0)) | edge_vec;
      if (wr_mask) irqmask <= wr_data;
      irq <= |(edgecapture & irqmask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = sync;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule
